spi_slave_byte: RTL and testbench

Synthesizable SPI slave (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit frames) that terminates the bench SPI master's cs_n/sclk/mosi/miso link inside the design. It oversamples the SPI pins on the system clock, deserializes mosi into bytes, and serializes a one-byte transmit holding register onto miso. Byte-level valid/ready interfaces face the command decoder. Multiple bytes per cs_n assertion are supported.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_byte.sv | 166 ++++++++++++++++
 tb/tb_spi_slave_byte.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared widths and FSM state type for the SPI byte slave.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned SPI_CNT_W  = 3;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall detection on the synced level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   hist;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {SYNC_STAGES{RESET_VAL}};
            hist   <= RESET_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
            hist   <= stages[SYNC_STAGES-1];
        end
    end

    assign rise_c =  stages[SYNC_STAGES-1] & ~hist;
    assign fall_c = ~stages[SYNC_STAGES-1] &  hist;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: oversampled pins, MSB-first rx deserializer and tx serializer
// with a one-byte transmit holding register.
module spi_slave_byte
    import spi_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE  = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_abort
);

    logic cs_rise_c, cs_fall_c, sclk_rise_c, sclk_fall_c;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s;

    spi_state_t state, state_n;
    logic [SPI_CNT_W-1:0]  cnt;
    logic [SPI_BYTE_W-1:0] rx_shift;
    logic [SPI_BYTE_W-1:0] tx_shift;
    logic [SPI_BYTE_W-1:0] hold;

    logic start_c, end_c, load_c, rx_step_c, tx_step_c;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (cs_n),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    // mosi needs only a level; its last stage lines up with the sclk edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state and datapath strobes; a cs_n rise masks any sclk edge in the same cycle.
    always_comb begin
        state_n   = state;
        start_c   = 1'b0;
        end_c     = 1'b0;
        load_c    = 1'b0;
        rx_step_c = 1'b0;
        tx_step_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_fall_c) begin
                    state_n = S_SHIFT;
                    start_c = 1'b1;
                    load_c  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cs_rise_c) begin
                    state_n = S_IDLE;
                    end_c   = 1'b1;
                end else if (sclk_rise_c) begin
                    rx_step_c = 1'b1;
                end else if (sclk_fall_c) begin
                    if (cnt == '0) load_c    = 1'b1;
                    else           tx_step_c = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Frame control, receive path and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            if (start_c) begin
                cnt     <= '0;
                busy    <= 1'b1;
                miso_oe <= 1'b1;
            end
            if (end_c) begin
                cnt         <= '0;
                busy        <= 1'b0;
                miso_oe     <= 1'b0;
                frame_abort <= (cnt != '0);
            end
            if (rx_step_c) begin
                rx_shift <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
                cnt      <= cnt + SPI_CNT_W'(1);
                if (cnt == SPI_CNT_W'(SPI_BYTE_W - 1)) begin
                    rx_data  <= {rx_shift[SPI_BYTE_W-2:0], mosi_s};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // Transmit path: holding register handshake, byte load points and miso shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold        <= '0;
            tx_ready    <= 1'b1;
            tx_shift    <= '0;
            miso        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (tx_valid && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
            if (load_c) begin
                if (!tx_ready) begin
                    tx_shift <= hold;
                    miso     <= hold[SPI_BYTE_W-1];
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift    <= IDLE_BYTE;
                    miso        <= IDLE_BYTE[SPI_BYTE_W-1];
                    tx_underrun <= 1'b1;
                end
            end
            if (tx_step_c) begin
                tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                miso     <= tx_shift[SPI_BYTE_W-2];
            end
            if (end_c) miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: bit-banged mode-0 master, rx scoreboard, pulse counters.
module tb_spi_slave_byte;

    localparam int HALF = 50;

    logic       clk, rst_n, cs_n, sclk, mosi;
    logic       miso, miso_oe, rx_valid, tx_valid, tx_ready, busy, tx_underrun, frame_abort;
    logic [7:0] rx_data, tx_data;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    int fa_cnt = 0;
    int r0, u0, f0;
    logic [7:0] rx_exp[$];

    spi_slave_byte #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every rx_valid, plus pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                chk("rx_pending", 32'(rx_exp.size() > 0), 32'd1);
                if (rx_exp.size() > 0) chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
            end
            if (tx_underrun === 1'b1) ur_cnt++;
            if (frame_abort === 1'b1) fa_cnt++;
        end
    end

    task automatic push_tx(input logic [7:0] d);
        bit done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) begin
                tx_data  = d;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                done     = 1;
            end
        end
        chk("push_tx_timeout", 32'(done), 32'd1);
    endtask

    // Mode-0 master; the last sclk fall and cs_n rise are driven together.
    task automatic spi_frame(input logic [7:0] m0, input logic [7:0] m1, input int nbytes,
                             input logic [7:0] s0, input logic [7:0] s1, input bit expect_data);
        logic [7:0] d, got, want;
        @(posedge clk);
        #7;
        cs_n = 1'b0;
        #(2*HALF);
        for (int k = 0; k < nbytes; k++) begin
            d    = (k == 0) ? m0 : m1;
            want = (k == 0) ? s0 : s1;
            got  = 8'h00;
            if (expect_data) rx_exp.push_back(d);
            for (int i = 7; i >= 0; i--) begin
                mosi = d[i];
                #HALF;
                got  = {got[6:0], miso};
                sclk = 1'b1;
                if (k == 0 && i == 7) begin
                    chk("busy_in_frame", 32'(busy), 32'd1);
                    chk("miso_oe_in_frame", 32'(miso_oe), 32'd1);
                end
                #HALF;
                sclk = 1'b0;
                if (k == nbytes - 1 && i == 0) cs_n = 1'b1;
            end
            if (expect_data) chk("master_miso", 32'(got), 32'(want));
        end
        mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic spi_partial(input int nbits);
        @(posedge clk);
        #7;
        cs_n = 1'b0;
        #(2*HALF);
        repeat (nbits) begin
            mosi = 1'b1;
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #(2*HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        #(4*HALF);
    endtask

    task automatic sclk_idle_toggle(input int n);
        @(posedge clk);
        #7;
        repeat (n) begin
            mosi = 1'($urandom_range(0, 1));
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        mosi = 1'b0;
        #(4*HALF);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(tx_underrun), 32'd0);
        chk("rst_abort", 32'(frame_abort), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Preloaded byte out, 0x3C in.
        push_tx(8'hA5);
        chk("t1_tx_ready_low", 32'(tx_ready), 32'd0);
        r0 = rx_cnt; u0 = ur_cnt;
        spi_frame(8'h3C, 8'h00, 1, 8'hA5, 8'h00, 1);
        chk("t1_rx_pulses", 32'(rx_cnt - r0), 32'd1);
        chk("t1_underruns", 32'(ur_cnt - u0), 32'd0);
        chk("t1_tx_ready", 32'(tx_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_miso_oe", 32'(miso_oe), 32'd0);
        chk("t1_rx_hold", 32'(rx_data), 32'h3C);

        // Empty holding register: idle byte and one underrun.
        r0 = rx_cnt; u0 = ur_cnt;
        spi_frame(8'hFF, 8'h00, 1, 8'h00, 8'h00, 1);
        chk("t2_rx_pulses", 32'(rx_cnt - r0), 32'd1);
        chk("t2_underruns", 32'(ur_cnt - u0), 32'd1);
        chk("t2_rx_hold", 32'(rx_data), 32'hFF);

        // Two bytes in one frame, second tx byte written mid-frame.
        push_tx(8'h56);
        r0 = rx_cnt; u0 = ur_cnt;
        fork
            spi_frame(8'h12, 8'h34, 2, 8'h56, 8'h78, 1);
            begin
                repeat (30) @(negedge clk);
                push_tx(8'h78);
            end
        join
        chk("t3_rx_pulses", 32'(rx_cnt - r0), 32'd2);
        chk("t3_underruns", 32'(ur_cnt - u0), 32'd0);
        chk("t3_tx_ready", 32'(tx_ready), 32'd1);

        // Partial byte then a clean byte.
        r0 = rx_cnt; u0 = ur_cnt; f0 = fa_cnt;
        spi_partial(3);
        chk("t4_rx_pulses", 32'(rx_cnt - r0), 32'd0);
        chk("t4_aborts", 32'(fa_cnt - f0), 32'd1);
        chk("t4_underruns", 32'(ur_cnt - u0), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_miso_oe", 32'(miso_oe), 32'd0);
        spi_frame(8'h81, 8'h00, 1, 8'h00, 8'h00, 1);
        chk("t4_rx_after", 32'(rx_cnt - r0), 32'd1);
        chk("t4_aborts_after", 32'(fa_cnt - f0), 32'd1);

        // Reset mid-byte, held until the master releases cs_n.
        push_tx(8'h11);
        chk("t5_tx_ready_low", 32'(tx_ready), 32'd0);
        r0 = rx_cnt; f0 = fa_cnt;
        fork
            spi_frame(8'h5C, 8'h00, 1, 8'h00, 8'h00, 0);
            begin
                @(posedge clk);
                #(7 + 520);
                rst_n = 1'b0;
                #1;
                chk("t5_miso_oe", 32'(miso_oe), 32'd0);
                chk("t5_tx_ready", 32'(tx_ready), 32'd1);
                chk("t5_busy", 32'(busy), 32'd0);
                chk("t5_rx_data", 32'(rx_data), 32'd0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_rx_pulses", 32'(rx_cnt - r0), 32'd0);
        chk("t5_aborts", 32'(fa_cnt - f0), 32'd0);
        spi_frame(8'hC3, 8'h00, 1, 8'h00, 8'h00, 1);
        chk("t5_rx_after", 32'(rx_cnt - r0), 32'd1);
        chk("t5_rx_hold", 32'(rx_data), 32'hC3);

        // sclk activity while deselected is ignored.
        r0 = rx_cnt; u0 = ur_cnt; f0 = fa_cnt;
        sclk_idle_toggle(8);
        chk("t6_rx_pulses", 32'(rx_cnt - r0), 32'd0);
        chk("t6_miso_oe", 32'(miso_oe), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cnt", 32'(dut.cnt), 32'd0);
        chk("t6_underruns", 32'(ur_cnt - u0), 32'd0);
        spi_frame(8'h5A, 8'h00, 1, 8'h00, 8'h00, 1);
        chk("t6_rx_after", 32'(rx_cnt - r0), 32'd1);
        chk("t6_aborts", 32'(fa_cnt - f0), 32'd0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(rx_exp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
